// File: rtl/video_dram_arb_pkg.sv
// Shared definitions for the video DRAM arbiter and the video mode decoder:
// window/need encodings of video_bw and the read-data owner tag.
package video_dram_arb_pkg;

    // video_bw[4:3]: window total (2'b10 is unused and treated as 8)
    localparam logic [1:0] BW2 = 2'b00;
    localparam logic [1:0] BW4 = 2'b01;
    localparam logic [1:0] BW8 = 2'b11;

    // video_bw[2:0]: one-hot number of video slots per window
    localparam logic [2:0] BU1 = 3'b001;
    localparam logic [2:0] BU2 = 3'b010;
    localparam logic [2:0] BU4 = 3'b100;

    // Who receives the next dram_rdy
    typedef enum logic [2:0] {
        OWN_NONE = 3'd0,
        OWN_VID  = 3'd1,
        OWN_CPU  = 3'd2,
        OWN_TS   = 3'd3,
        OWN_DMA  = 3'd4
    } owner_t;

    function automatic logic [3:0] bw_total(input logic [1:0] code);
        case (code)
            BW2:     bw_total = 4'd2;
            BW4:     bw_total = 4'd4;
            BW8:     bw_total = 4'd8;
            default: bw_total = 4'd8;
        endcase
    endfunction

    // A non-one-hot need field gives video no slots at all
    function automatic logic [3:0] bw_need(input logic [2:0] code);
        case (code)
            BU1:     bw_need = 4'd1;
            BU2:     bw_need = 4'd2;
            BU4:     bw_need = 4'd4;
            default: bw_need = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/dram_slot_window.sv
// Slot window tracker: counts DRAM slots inside the current video bandwidth
// window and flags the slots that belong to video fetch.
module dram_slot_window
    import video_dram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       dram_stb,
    input  logic       video_go,
    input  logic [4:0] video_bw,
    output logic       video_slot
);

    logic [2:0] win_cnt_q, win_cnt_d;
    logic [3:0] tot_q, tot_d;
    logic [3:0] need_q, need_d;
    logic [3:0] tot_eff, need_eff, cnt_inc;

    // Window start uses the live video_bw; later slots use the value latched there
    always_comb begin
        tot_eff    = (win_cnt_q == 3'd0) ? bw_total(video_bw[4:3]) : tot_q;
        need_eff   = (win_cnt_q == 3'd0) ? bw_need(video_bw[2:0])  : need_q;
        video_slot = video_go && ({1'b0, win_cnt_q} < need_eff);
        cnt_inc    = {1'b0, win_cnt_q} + 4'd1;
        win_cnt_d  = win_cnt_q;
        tot_d      = tot_q;
        need_d     = need_q;
        if (dram_stb) begin
            if (!video_go) begin
                win_cnt_d = 3'd0;
            end else begin
                tot_d     = tot_eff;
                need_d    = need_eff;
                win_cnt_d = (cnt_inc >= tot_eff) ? 3'd0 : cnt_inc[2:0];
            end
        end
    end

    // Window state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt_q <= 3'd0;
            tot_q     <= 4'd2;
            need_q    <= 4'd0;
        end else begin
            win_cnt_q <= win_cnt_d;
            tot_q     <= tot_d;
            need_q    <= need_d;
        end
    end

endmodule

// File: rtl/video_dram_arb.sv
// DRAM slot arbiter: video takes its guaranteed window slots, the rest go to
// CPU first and then TS/DMA round-robin. Read data is steered back to the
// owner of the last read via a one-entry owner tag.
module video_dram_arb
    import video_dram_arb_pkg::*;
#(
    parameter int AW = 21,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          res,
    input  logic          dram_stb,
    input  logic          video_go,
    input  logic [4:0]    video_bw,
    input  logic [AW-1:0] video_addr,
    input  logic          cpu_req,
    input  logic          cpu_rnw,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          ts_req,
    input  logic [AW-1:0] ts_addr,
    input  logic          dma_req,
    input  logic          dma_rnw,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    input  logic          dram_rdy,
    input  logic [DW-1:0] dram_rdata,
    output logic          dram_req,
    output logic          dram_rnw,
    output logic [AW-1:0] dram_addr,
    output logic [DW-1:0] dram_wdata,
    output logic          video_next,
    output logic          video_strb,
    output logic          cpu_gnt,
    output logic          ts_gnt,
    output logic          dma_gnt,
    output logic          cpu_strb,
    output logic          ts_strb,
    output logic          dma_strb
);

    logic          video_slot;
    logic          req_q, req_d, rnw_q, rnw_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          vnext_q, vnext_d;
    logic          cpu_gnt_q, cpu_gnt_d, ts_gnt_q, ts_gnt_d, dma_gnt_q, dma_gnt_d;
    logic          rr_dma_q, rr_dma_d;   // 1: DMA has priority over TS on the next free slot
    owner_t        owner_q, owner_d, grant_own;

    // Read data itself goes straight to the requesters; only its valid strobe is routed here
    logic unused_rdata;
    assign unused_rdata = ^dram_rdata;

    dram_slot_window u_window (
        .clk        (clk),
        .rst        (res),
        .dram_stb   (dram_stb),
        .video_go   (video_go),
        .video_bw   (video_bw),
        .video_slot (video_slot)
    );

    // Slot decision, command mux and owner-tag update
    always_comb begin
        req_d     = 1'b0;
        rnw_d     = rnw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        vnext_d   = 1'b0;
        cpu_gnt_d = 1'b0;
        ts_gnt_d  = 1'b0;
        dma_gnt_d = 1'b0;
        rr_dma_d  = rr_dma_q;
        grant_own = OWN_NONE;
        owner_d   = dram_rdy ? OWN_NONE : owner_q;
        if (dram_stb) begin
            if (video_slot) begin
                req_d     = 1'b1;
                rnw_d     = 1'b1;
                addr_d    = video_addr;
                vnext_d   = 1'b1;
                grant_own = OWN_VID;
            end else if (cpu_req) begin
                req_d     = 1'b1;
                rnw_d     = cpu_rnw;
                addr_d    = cpu_addr;
                wdata_d   = cpu_wdata;
                cpu_gnt_d = 1'b1;
                grant_own = OWN_CPU;
            end else if (ts_req && (!rr_dma_q || !dma_req)) begin
                req_d     = 1'b1;
                rnw_d     = 1'b1;
                addr_d    = ts_addr;
                ts_gnt_d  = 1'b1;
                rr_dma_d  = 1'b1;
                grant_own = OWN_TS;
            end else if (dma_req) begin
                req_d     = 1'b1;
                rnw_d     = dma_rnw;
                addr_d    = dma_addr;
                wdata_d   = dma_wdata;
                dma_gnt_d = 1'b1;
                rr_dma_d  = 1'b0;
                grant_own = OWN_DMA;
            end
        end
        // A new grant overrides the clear from a coincident dram_rdy
        if (req_d) begin
            owner_d = rnw_d ? grant_own : OWN_NONE;
        end
    end

    // Registered command, grants and arbitration state
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            req_q     <= 1'b0;
            rnw_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            vnext_q   <= 1'b0;
            cpu_gnt_q <= 1'b0;
            ts_gnt_q  <= 1'b0;
            dma_gnt_q <= 1'b0;
            rr_dma_q  <= 1'b0;
            owner_q   <= OWN_NONE;
        end else begin
            req_q     <= req_d;
            rnw_q     <= rnw_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            vnext_q   <= vnext_d;
            cpu_gnt_q <= cpu_gnt_d;
            ts_gnt_q  <= ts_gnt_d;
            dma_gnt_q <= dma_gnt_d;
            rr_dma_q  <= rr_dma_d;
            owner_q   <= owner_d;
        end
    end

    assign dram_req   = req_q;
    assign dram_rnw   = rnw_q;
    assign dram_addr  = addr_q;
    assign dram_wdata = wdata_q;
    assign video_next = vnext_q;
    assign cpu_gnt    = cpu_gnt_q;
    assign ts_gnt     = ts_gnt_q;
    assign dma_gnt    = dma_gnt_q;

    // Read-data-valid follows the tag of the outstanding read in the same cycle
    assign video_strb = dram_rdy && (owner_q == OWN_VID);
    assign cpu_strb   = dram_rdy && (owner_q == OWN_CPU);
    assign ts_strb    = dram_rdy && (owner_q == OWN_TS);
    assign dma_strb   = dram_rdy && (owner_q == OWN_DMA);

endmodule

// File: tb/tb_video_dram_arb.sv
// Bench for video_dram_arb: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a slot-level model.
module tb_video_dram_arb;

    localparam int AW = 21;
    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          res = 1'b1;
    logic          dram_stb = 0, video_go = 0, cpu_req = 0, cpu_rnw = 0, ts_req = 0;
    logic          dma_req = 0, dma_rnw = 0, dram_rdy = 0;
    logic [4:0]    video_bw = 0;
    logic [AW-1:0] video_addr = 0, cpu_addr = 0, ts_addr = 0, dma_addr = 0;
    logic [DW-1:0] cpu_wdata = 0, dma_wdata = 0, dram_rdata = 0;
    logic          dram_req, dram_rnw, video_next, video_strb;
    logic          cpu_gnt, ts_gnt, dma_gnt, cpu_strb, ts_strb, dma_strb;
    logic [AW-1:0] dram_addr;
    logic [DW-1:0] dram_wdata;

    video_dram_arb #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .res(res), .dram_stb(dram_stb), .video_go(video_go),
        .video_bw(video_bw), .video_addr(video_addr),
        .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .ts_req(ts_req), .ts_addr(ts_addr),
        .dma_req(dma_req), .dma_rnw(dma_rnw), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dram_rdy(dram_rdy), .dram_rdata(dram_rdata),
        .dram_req(dram_req), .dram_rnw(dram_rnw), .dram_addr(dram_addr), .dram_wdata(dram_wdata),
        .video_next(video_next), .video_strb(video_strb),
        .cpu_gnt(cpu_gnt), .ts_gnt(ts_gnt), .dma_gnt(dma_gnt),
        .cpu_strb(cpu_strb), .ts_strb(ts_strb), .dma_strb(dma_strb)
    );

    int n_pass = 0;
    int n_chk  = 0;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model (owner codes: 0 none, 1 video, 2 cpu, 3 ts, 4 dma)
    int            m_pos, m_tot, m_need, m_owner;
    bit            m_rr_dma;
    bit            e_req, e_rnw, e_vn;
    int            e_gnt, e_strb;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    bit            n_req, n_rnw, n_vn, n_rr;
    int            n_gnt, n_owner, n_pos, n_tot, n_need;
    logic [AW-1:0] n_addr;
    logic [DW-1:0] n_wdata;
    int            cyc = 0;
    bit            chk_en = 0;
    bit            started = 0;

    function automatic int tot_of(input logic [1:0] c);
        case (c)
            2'b00:   return 2;
            2'b01:   return 4;
            default: return 8;
        endcase
    endfunction

    function automatic int need_of(input logic [2:0] c);
        case (c)
            3'b001:  return 1;
            3'b010:  return 2;
            3'b100:  return 4;
            default: return 0;
        endcase
    endfunction

    // What the outputs show this cycle (strobes) and after the coming edge (command)
    task automatic eval();
        bit vid;
        vid     = 0;
        e_strb  = dram_rdy ? m_owner : 0;
        n_req   = 0; n_gnt = 0; n_vn = 0;
        n_rnw   = e_rnw; n_addr = e_addr; n_wdata = e_wdata;
        n_owner = dram_rdy ? 0 : m_owner;
        n_pos   = m_pos; n_tot = m_tot; n_need = m_need; n_rr = m_rr_dma;
        if (dram_stb) begin
            if (!video_go) begin
                n_pos = 0;
            end else begin
                if (m_pos == 0) begin
                    n_tot  = tot_of(video_bw[4:3]);
                    n_need = need_of(video_bw[2:0]);
                end
                vid   = (m_pos < n_need);
                n_pos = (m_pos + 1) % n_tot;
            end
            if (vid) begin
                n_gnt = 1; n_rnw = 1; n_addr = video_addr;
            end else if (cpu_req) begin
                n_gnt = 2; n_rnw = cpu_rnw; n_addr = cpu_addr; n_wdata = cpu_wdata;
            end else if (ts_req && (!m_rr_dma || !dma_req)) begin
                n_gnt = 3; n_rnw = 1; n_addr = ts_addr; n_rr = 1;
            end else if (dma_req) begin
                n_gnt = 4; n_rnw = dma_rnw; n_addr = dma_addr; n_wdata = dma_wdata; n_rr = 0;
            end
            if (n_gnt != 0) begin
                n_req   = 1;
                n_vn    = (n_gnt == 1);
                n_owner = n_rnw ? n_gnt : 0;
            end
        end
    endtask

    task automatic step();
        eval();
        @(posedge clk);
        #1;
        e_req = n_req; e_rnw = n_rnw; e_vn = n_vn; e_gnt = n_gnt;
        e_addr = n_addr; e_wdata = n_wdata;
        m_owner = n_owner; m_pos = n_pos; m_tot = n_tot; m_need = n_need; m_rr_dma = n_rr;
        cyc++;
    endtask

    function automatic logic [47:0] all_outs();
        return {dram_req, dram_rnw, dram_addr, dram_wdata, video_next, video_strb,
                cpu_gnt, ts_gnt, dma_gnt, cpu_strb, ts_strb, dma_strb};
    endfunction

    task automatic do_reset();
        dram_stb = 0; dram_rdy = 0;
        res = 1;
        m_pos = 0; m_tot = 2; m_need = 0; m_owner = 0; m_rr_dma = 0;
        e_req = 0; e_rnw = 0; e_vn = 0; e_gnt = 0; e_strb = 0; e_addr = '0; e_wdata = '0;
        #1;
        if (started) check("rst_async", all_outs(), 48'h0);
        @(posedge clk); #1;
        check("rst_outs", all_outs(), 48'h0);
        @(posedge clk); #1;
        res = 0;
        started = 1;
    endtask

    // ---------------- compare process and grant log
    logic [63:0] gseq = '0;
    int          gcnt = 0;
    int          vn_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en && !res) begin
                check("ctrl",
                      {dram_req, video_next, cpu_gnt, ts_gnt, dma_gnt,
                       video_strb, cpu_strb, ts_strb, dma_strb},
                      {e_req, e_vn, e_gnt == 2, e_gnt == 3, e_gnt == 4,
                       e_strb == 1, e_strb == 2, e_strb == 3, e_strb == 4});
                if (e_req) begin
                    check("rnw", dram_rnw, e_rnw);
                    check("addr", dram_addr, e_addr);
                    if (!e_rnw) check("wdata", dram_wdata, e_wdata);
                end
            end
            if (!res && dram_req) begin
                gseq = {gseq[59:0], video_next ? 4'h1 : cpu_gnt ? 4'h2 : ts_gnt ? 4'h3 :
                                    dma_gnt ? 4'h4 : 4'h0};
                gcnt++;
                $display("slot grant code=%0h addr=0x%0h rnw=%0b t=%0t",
                         gseq[3:0], dram_addr, dram_rnw, $time);
            end
            if (!res && video_next) vn_cnt++;
        end
    end

    task automatic slot();
        dram_stb = 1; video_addr = AW'($urandom);
        step();
        dram_stb = 0;
        step();
        dram_rdy = 1; dram_rdata = DW'($urandom);
        step();
        dram_rdy = 0;
    endtask

    // ---------------- stimulus
    logic [4:0] bw_tab [9] = '{5'b00001, 5'b00010, 5'b00100, 5'b01001, 5'b01010,
                                5'b01100, 5'b11001, 5'b11010, 5'b11100};
    int g0, v0, next_stb, rdy_cyc, gap;

    initial begin
        do_reset();
        chk_en = 1;

        // 1 of 4 with CPU held
        do_reset();
        video_go = 1; video_bw = 5'b01_001;
        cpu_req = 1; cpu_rnw = 0; cpu_addr = 21'h00123; cpu_wdata = 16'hBEEF;
        g0 = gcnt; v0 = vn_cnt;
        repeat (8) slot();
        check("t1_seq", gseq[31:0], 32'h12221222);
        check("t1_cnt", gcnt - g0, 8);
        check("t1_vnext", vn_cnt - v0, 2);

        // 4 of 8 with TS and DMA held
        do_reset();
        cpu_req = 0; ts_req = 1; ts_addr = 21'h0AAAA; dma_req = 1; dma_rnw = 1;
        dma_addr = 21'h15555; video_bw = 5'b11_100;
        repeat (8) slot();
        check("t2_seq", gseq[31:0], 32'h11113434);
        ts_req = 0; dma_req = 0;

        // bandwidth change mid-window
        do_reset();
        cpu_req = 1; video_bw = 5'b11_001;
        g0 = gcnt;
        repeat (3) slot();
        video_bw = 5'b00_001;
        repeat (9) slot();
        check("t3_seq", gseq[47:0], 48'h122222221212);
        check("t3_cnt", gcnt - g0, 12);

        // video_go drop at win_cnt 1
        do_reset();
        video_bw = 5'b11_010;
        slot();
        video_go = 0;
        repeat (2) slot();
        video_go = 1;
        repeat (3) slot();
        check("t4_seq", gseq[23:0], 24'h122112);

        // CPU read, rdy coincident with TS grant
        do_reset();
        video_go = 0; cpu_req = 1; cpu_rnw = 1; cpu_addr = 21'h1ABCD;
        dram_stb = 1; step();
        dram_stb = 0; cpu_req = 0;
        check("t5_addr", dram_addr, 21'h1ABCD);
        check("t5_gnt", {cpu_gnt, dram_rnw}, 2'b11);
        step();
        ts_req = 1; ts_addr = 21'h00042; dram_stb = 1; dram_rdy = 1; dram_rdata = 16'h5A3C;
        #1;
        check("t5_cpu_strb", {video_strb, cpu_strb, ts_strb, dma_strb}, 4'b0100);
        step();
        dram_stb = 0; dram_rdy = 0; ts_req = 0;
        check("t5_ts_gnt", {ts_gnt, dram_addr}, {1'b1, 21'h00042});
        step();
        dram_rdy = 1; dram_rdata = 16'h1234;
        #1;
        check("t5_ts_strb", {video_strb, cpu_strb, ts_strb, dma_strb}, 4'b0010);
        step();
        dram_rdy = 0;
        step();

        // reset between video grant and its rdy
        do_reset();
        video_go = 1; video_bw = 5'b00_001;
        dram_stb = 1; step();
        dram_stb = 0;
        check("t6_vnext", video_next, 1'b1);
        do_reset();
        dram_rdy = 1;
        #1;
        check("t6_no_strb", video_strb, 1'b0);
        step();
        dram_rdy = 0;
        step();
        check("t6_zero", all_outs(), 48'h0);

        // randomized traffic
        do_reset();
        cpu_req = 0; ts_req = 0; dma_req = 0;
        next_stb = cyc + 1; rdy_cyc = -1; gap = 2;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                do_reset();
                next_stb = cyc + 2; rdy_cyc = -1;
            end
            dram_stb = (cyc == next_stb);
            if (dram_stb) begin
                gap = $urandom_range(2, 5);
                next_stb = cyc + gap;
            end
            dram_rdy = (cyc == rdy_cyc) ||
                       (m_owner == 0 && rdy_cyc < cyc && $urandom_range(0, 19) == 0);
            dram_rdata = DW'($urandom);
            video_addr = AW'($urandom);
            if ($urandom_range(0, 39) == 0) video_go = ~video_go;
            if ($urandom_range(0, 29) == 0) video_bw = bw_tab[$urandom_range(0, 8)];
            if (e_gnt == 2 || !cpu_req) begin
                cpu_req = ($urandom_range(0, 2) == 0);
                cpu_rnw = $urandom_range(0, 1); cpu_addr = AW'($urandom); cpu_wdata = DW'($urandom);
            end else if ($urandom_range(0, 49) == 0) cpu_req = 0;
            if (e_gnt == 3 || !ts_req) begin
                ts_req = ($urandom_range(0, 2) == 0); ts_addr = AW'($urandom);
            end else if ($urandom_range(0, 49) == 0) ts_req = 0;
            if (e_gnt == 4 || !dma_req) begin
                dma_req = ($urandom_range(0, 2) == 0);
                dma_rnw = $urandom_range(0, 1); dma_addr = AW'($urandom); dma_wdata = DW'($urandom);
            end else if ($urandom_range(0, 49) == 0) dma_req = 0;
            step();
            if (e_req && e_rnw) rdy_cyc = cyc + $urandom_range(1, gap - 1);
        end
        dram_stb = 0; dram_rdy = 0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
